// File: rtl/seg7_disp_arbiter_if.sv
// seg7_disp_arbiter_if
//   Bus between the three display sources and the seg7 arbiter.
//   master : source side, drives req/data0..2/freeze and observes gnt/dout/busy.
//   slave  : arbiter side, samples the requests and drives the registered grant,
//            the display word and busy.
interface seg7_disp_arbiter_if;
  logic [2:0]  req;
  logic [23:0] data0;
  logic [23:0] data1;
  logic [23:0] data2;
  logic        freeze;
  logic [2:0]  gnt;
  logic [23:0] dout;
  logic        busy;

  modport master (
    output req, data0, data1, data2, freeze,
    input  gnt, dout, busy
  );

  modport slave (
    input  req, data0, data1, data2, freeze,
    output gnt, dout, busy
  );
endinterface

// File: rtl/seg7_disp_arbiter.sv
// seg7_disp_arbiter
//   Round-robin sharing of the six-digit seg7 scanner between three BCD
//   sources (clock, stopwatch, counter). A grant is held for at least DWELL
//   cycles while others wait; freeze pins the current holder on screen.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous reset, active-high
//   bus  - slave modport: req[2:0], data0/1/2[23:0], freeze in;
//          gnt[2:0] (one-hot), dout[23:0], busy out, all registered
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no source granted, dout shows IDLE_DATA
// HOLD  | source lp_q owns the display, dwell counter running/expired
module seg7_disp_arbiter #(
  parameter int unsigned DWELL     = 25_000_000,
  parameter logic [23:0] IDLE_DATA = 24'hFFFFFF
) (
  input  logic                clk,
  input  logic                rst,
  seg7_disp_arbiter_if.slave  bus
);

  localparam int unsigned   CW     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t        state_q, state_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [23:0]   dout_q, dout_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    lp_q, lp_d;

  logic [2:0]    holder_oh;
  logic [2:0]    others;
  logic [2:0]    cand;
  logic [1:0]    pick;
  logic          grant_now;

  // Search order from pointer p: p+1, p+2, p (mod 3).
  function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [2:0] r);
    logic [1:0] c1, c2, res;
    c1  = (p == 2'd2) ? 2'd0 : p + 2'd1;
    c2  = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    res = p;
    if (r[c1])      res = c1;
    else if (r[c2]) res = c2;
    return res;
  endfunction

  function automatic logic [2:0] to_onehot(input logic [1:0] i);
    logic [2:0] oh;
    oh = 3'b000;
    case (i)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  always_comb begin
    holder_oh = to_onehot(lp_q);
    others    = bus.req & ~holder_oh;
    // In HOLD the holder is excluded so a search can never re-pick it
    cand      = (state_q == ST_IDLE) ? bus.req : others;
    pick      = rr_pick(lp_q, cand);
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    lp_d      = lp_q;
    grant_now = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|bus.req) grant_now = 1'b1;
      end
      ST_HOLD: begin
        if (!bus.req[lp_q]) begin
          // Holder released: hand over immediately, ignoring dwell and freeze
          if (|others) begin
            grant_now = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 3'b000;
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!bus.freeze) begin
          if (|others) grant_now = 1'b1;
          else         cnt_d     = RELOAD;
        end
        // Expired and frozen: hold with counter parked at zero
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 3'b000;
      end
    endcase

    if (grant_now) begin
      state_d = ST_HOLD;
      gnt_d   = to_onehot(pick);
      cnt_d   = RELOAD;
      lp_d    = pick;
    end
  end

  // dout follows the next holder's live data, not a snapshot taken at grant
  always_comb begin
    case (gnt_d)
      3'b001:  dout_d = bus.data0;
      3'b010:  dout_d = bus.data1;
      3'b100:  dout_d = bus.data2;
      default: dout_d = IDLE_DATA;
    endcase
    busy_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 3'b000;
      dout_q  <= IDLE_DATA;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      lp_q    <= 2'd2;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      lp_q    <= lp_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.dout = dout_q;
  assign bus.busy = busy_q;

endmodule
